digit_serial_add_sub: RTL and testbench

//  Multi-cycle add/subtract unit: S = A + (-1)^k * B, computed LSB-first, D bits per clock.

---
 rtl/digit_serial_add_sub.sv | 133 +++++++++++++
 tb/tb_digit_serial_add_sub.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_add_sub.sv
// Digit-serial adder/subtractor: S = A +/- B over N/D clock cycles, D bits per cycle, LSB first.
// Produces the exact (N+1)-bit result plus an N-bit overflow flag, behind a start/done handshake.
module digit_serial_add_sub #(
  parameter int N = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         k,
  input  logic         sgn,
  output logic         busy,
  output logic         done,
  output logic [N:0]   S,
  output logic         ovf
);

  localparam int NDIG = N / D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic           k_q, k_d, sgn_q, sgn_d, carry_q, carry_d;
  logic           a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N:0]     s_q, s_d;
  logic           ovf_q, ovf_d;

  logic           accept, last;
  logic [D:0]     dsum;
  logic [N+D-1:0] acc_cat;
  logic [N-1:0]   sum_n;
  logic           top_bit;

  assign accept = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign last   = (state_q == RUN) && (cnt_q == CW'(NDIG - 1));

  // One digit of A + (B ^ k) + carry; the operand registers shift right so bit 0 is always current.
  assign dsum    = {1'b0, a_q[D-1:0]} + {1'b0, b_q[D-1:0] ^ {D{k_q}}} + {{D{1'b0}}, carry_q};
  assign acc_cat = {dsum[D-1:0], acc_q};
  assign sum_n   = acc_cat[N+D-1:D];
  // Extra result bit: undo the borrow inversion for unsigned, sign-extend the operands for signed.
  assign top_bit = sgn_q ? (a_msb_q ^ b_msb_q ^ k_q ^ dsum[D]) : (dsum[D] ^ k_q);

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    sgn_d   = sgn_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = A;
      b_d     = B;
      k_d     = k;
      sgn_d   = sgn;
      carry_d = k;
      a_msb_d = A[N-1];
      b_msb_d = B[N-1];
      cnt_d   = '0;
      acc_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> D;
      b_d     = b_q >> D;
      carry_d = dsum[D];
      acc_d   = sum_n;
      cnt_d   = cnt_q + 1'b1;
      if (last) begin
        s_d   = {top_bit, sum_n};
        ovf_d = sgn_q ? (top_bit ^ sum_n[N-1]) : top_bit;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= 1'b0;
      sgn_q   <= 1'b0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      sgn_q   <= sgn_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    S    = s_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Bench for digit_serial_add_sub: four instances (N=8, D=1/2/4/8) driven in lockstep and
// compared cycle by cycle against an integer-arithmetic reference model.
module tb_digit_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v [4];
  logic [7:0] a_v     [4];
  logic [7:0] b_v     [4];
  logic       k_v     [4];
  logic       sgn_v   [4];
  logic       busy_v  [4];
  logic       done_v  [4];
  logic [8:0] s_v     [4];
  logic       ovf_v   [4];

  logic [8:0] prev_s [4];
  logic       prev_o [4];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    digit_serial_add_sub #(.N(8), .D(1 << g)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start_v[g]),
      .A     (a_v[g]),
      .B     (b_v[g]),
      .k     (k_v[g]),
      .sgn   (sgn_v[g]),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .S     (s_v[g]),
      .ovf   (ovf_v[g])
    );
  end

  // Reference: exact integer sum/difference, read back as 9 bits; overflow means it misses 8 bits.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic kk,
                                input logic sg, output logic [8:0] s, output logic o);
    int av, bv, r;
    if (sg) begin
      av = int'($signed(a));
      bv = int'($signed(b));
    end else begin
      av = int'(a);
      bv = int'(b);
    end
    r = kk ? av - bv : av + bv;
    s = r[8:0];
    o = sg ? (r < -128 || r > 127) : (r < 0 || r > 255);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; k_v[i] = 1'b0; sgn_v[i] = 1'b0;
      prev_s[i] = '0; prev_o[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || s_v[i] !== 9'h000 || ovf_v[i] !== 1'b0) begin
        mismatched++;
        $display("FAIL reset inst%0d: busy=%b done=%b S=%h ovf=%b, expected all zero",
                 i, busy_v[i], done_v[i], s_v[i], ovf_v[i]);
      end
    end
    rst = 1'b0;
  endtask

  // Launch one operation on all instances and check busy/done/S/ovf every cycle until all are idle.
  // With hold set, start stays high through RUN and the operand inputs are scrambled after accept.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic kk, input logic sg, input logic [8:0] es,
                        input logic eo, input bit hold);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a_v[i] = a; b_v[i] = b; k_v[i] = kk; sgn_v[i] = sg; start_v[i] = 1'b1;
    end
    @(posedge clk);
    for (int m = 0; m <= 9; m++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        int         l;
        logic [8:0] xs;
        logic       xo;
        l  = 8 >> i;
        xs = (m >= l) ? es : prev_s[i];
        xo = (m >= l) ? eo : prev_o[i];
        compared++;
        if (busy_v[i] !== (m < l)) begin
          mismatched++;
          $display("FAIL %s inst%0d busy m=%0d: got %b expected %b", name, i, m, busy_v[i], m < l);
        end
        compared++;
        if (done_v[i] !== (m == l)) begin
          mismatched++;
          $display("FAIL %s inst%0d done m=%0d: got %b expected %b", name, i, m, done_v[i], m == l);
        end
        compared++;
        if (s_v[i] !== xs) begin
          mismatched++;
          $display("FAIL %s inst%0d S m=%0d: got %h expected %h", name, i, m, s_v[i], xs);
        end
        compared++;
        if (ovf_v[i] !== xo) begin
          mismatched++;
          $display("FAIL %s inst%0d ovf m=%0d: got %b expected %b", name, i, m, ovf_v[i], xo);
        end
        start_v[i] = hold && (m + 1 <= l);
        if (hold) begin
          a_v[i] = 8'($urandom); b_v[i] = 8'($urandom);
          k_v[i] = 1'($urandom); sgn_v[i] = 1'($urandom);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      prev_s[i] = es; prev_o[i] = eo;
    end
  endtask

  task automatic test_directed();
    run_op("uadd",    8'd200, 8'd100, 1'b0, 1'b0, 9'h12C, 1'b1, 1'b0);
    run_op("usub_neg", 8'd5,  8'd9,   1'b1, 1'b0, 9'h1FC, 1'b1, 1'b0);
    run_op("usub_pos", 8'd9,  8'd5,   1'b1, 1'b0, 9'h004, 1'b0, 1'b0);
    run_op("sadd_min", 8'h80, 8'hFF,  1'b0, 1'b1, 9'h17F, 1'b1, 1'b0);
    run_op("ssub",     8'd3,  8'd5,   1'b1, 1'b1, 9'h1FE, 1'b0, 1'b0);
  endtask

  task automatic test_handshake();
    run_op("hold_start", 8'd200, 8'd100, 1'b0, 1'b0, 9'h12C, 1'b1, 1'b1);
    run_op("hold_ssub",  8'h7F,  8'h80,  1'b1, 1'b1, 9'h0FF, 1'b1, 1'b1);
  endtask

  // A new start in the DONE cycle must be accepted and finish exactly L+1 cycles after the first done.
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      int         l;
      logic [7:0] a1, b1, a2, b2;
      logic       k1, g1, k2, g2, o1, o2;
      logic [8:0] s1, s2;
      l  = 8 >> i;
      a1 = 8'($urandom); b1 = 8'($urandom); k1 = 1'($urandom); g1 = 1'($urandom);
      a2 = 8'($urandom); b2 = 8'($urandom); k2 = 1'($urandom); g2 = 1'($urandom);
      model(a1, b1, k1, g1, s1, o1);
      model(a2, b2, k2, g2, s2, o2);
      @(negedge clk);
      a_v[i] = a1; b_v[i] = b1; k_v[i] = k1; sgn_v[i] = g1; start_v[i] = 1'b1;
      @(posedge clk);
      for (int m = 0; m <= 2 * l + 2; m++) begin
        logic       xb, xd, xo;
        logic [8:0] xs;
        @(negedge clk);
        xb = (m < l) || (m >= l + 1 && m < 2 * l + 1);
        xd = (m == l) || (m == 2 * l + 1);
        xs = (m < l) ? prev_s[i] : (m < 2 * l + 1) ? s1 : s2;
        xo = (m < l) ? prev_o[i] : (m < 2 * l + 1) ? o1 : o2;
        compared++;
        if (busy_v[i] !== xb || done_v[i] !== xd) begin
          mismatched++;
          $display("FAIL b2b inst%0d m=%0d: busy/done got %b%b expected %b%b",
                   i, m, busy_v[i], done_v[i], xb, xd);
        end
        compared++;
        if (s_v[i] !== xs || ovf_v[i] !== xo) begin
          mismatched++;
          $display("FAIL b2b inst%0d m=%0d: S/ovf got %h/%b expected %h/%b",
                   i, m, s_v[i], ovf_v[i], xs, xo);
        end
        start_v[i] = (m == l);
        if (m == l) begin
          a_v[i] = a2; b_v[i] = b2; k_v[i] = k2; sgn_v[i] = g2;
        end
      end
      prev_s[i] = s2; prev_o[i] = o2;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [8:0] es;
    logic       eo;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a_v[i] = 8'd77; b_v[i] = 8'd33; k_v[i] = 1'b0; sgn_v[i] = 1'b0; start_v[i] = 1'b1;
    end
    @(posedge clk);
    for (int m = 0; m <= 12; m++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        logic xd;
        xd = (m == 1) && ((8 >> i) == 1);
        start_v[i] = 1'b0;
        compared++;
        if (done_v[i] !== xd) begin
          mismatched++;
          $display("FAIL rst_mid inst%0d done m=%0d: got %b expected %b", i, m, done_v[i], xd);
        end
        if (m >= 2) begin
          compared++;
          if (busy_v[i] !== 1'b0 || s_v[i] !== 9'h000 || ovf_v[i] !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid inst%0d m=%0d: busy=%b S=%h ovf=%b expected 0/000/0",
                     i, m, busy_v[i], s_v[i], ovf_v[i]);
          end
        end
        prev_s[i] = '0; prev_o[i] = 1'b0;
      end
      rst = (m == 1) || (m == 2);
    end
    model(8'd250, 8'd6, 1'b0, 1'b0, es, eo);
    run_op("after_rst", 8'd250, 8'd6, 1'b0, 1'b0, es, eo, 1'b0);
  endtask

  task automatic test_random();
    for (int mode = 0; mode < 4; mode++) begin
      for (int n = 0; n < 1000; n++) begin
        logic [7:0] a, b;
        logic [8:0] es;
        logic       eo, kk, sg;
        logic [7:0] corners [4];
        corners = '{8'h00, 8'hFF, 8'h80, 8'h7F};
        kk = mode[0];
        sg = mode[1];
        a  = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : 8'($urandom);
        b  = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : 8'($urandom);
        model(a, b, kk, sg, es, eo);
        run_op("random", a, b, kk, sg, es, eo, $urandom_range(0, 7) == 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
